// File: rtl/mpdmac_cfg.sv
// APB register file for the mirror-padding DMA engine: holds addresses and width,
// validates launch requests, sequences the start/ack/run handshake and raises the completion/error interrupt.
module mpdmac_cfg #(
    parameter logic [31:0] VERSION = 32'h0001_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [11:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [5:0]  mat_width_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o
);

    localparam logic [9:0] A_VERSION = 10'h000;
    localparam logic [9:0] A_SRC     = 10'h040;
    localparam logic [9:0] A_DST     = 10'h041;
    localparam logic [9:0] A_MATW    = 10'h042;
    localparam logic [9:0] A_CMD     = 10'h043;
    localparam logic [9:0] A_STATUS  = 10'h044;
    localparam logic [9:0] A_INTEN   = 10'h045;
    localparam logic [9:0] A_INTSTS  = 10'h046;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ACK   = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [5:0]  r_mat_w;
    logic [1:0]  r_int_en;
    logic [1:0]  r_int_sts;
    logic        r_irq;

    logic [9:0]  w_word;
    logic        w_access;
    logic        w_wr;
    logic        w_rd;
    logic        w_mapped;
    logic        w_busy;
    logic        w_cmd_busy;
    logic        w_mat_valid;
    logic        w_launch_req;
    logic        w_launch;
    logic        w_err_set;
    logic        w_done_set;
    logic [1:0]  w_clr;
    logic [1:0]  w_set;
    logic [1:0]  w_int_sts_next;
    logic        w_cfg_sel;
    logic        w_unused;

    assign w_unused = &{1'b0, paddr_i[1:0]};

    assign w_word      = paddr_i[11:2];
    assign w_access    = psel_i & penable_i;
    assign w_wr        = w_access & pwrite_i;
    assign w_rd        = w_access & ~pwrite_i;
    assign pready_o    = w_access;
    assign w_busy      = (r_state != ST_IDLE);
    // An engine not reporting done while we sit in IDLE is still considered busy for launches.
    assign w_cmd_busy  = w_busy | ~done_i;
    assign w_mat_valid = ~r_mat_w[0] && (r_mat_w >= 6'd2) && (r_mat_w <= 6'd60);
    assign w_cfg_sel   = (w_word == A_SRC) || (w_word == A_DST) || (w_word == A_MATW);

    assign w_mapped = (w_word == A_VERSION) || (w_word == A_SRC) || (w_word == A_DST) ||
                      (w_word == A_MATW) || (w_word == A_CMD) || (w_word == A_STATUS) ||
                      (w_word == A_INTEN) || (w_word == A_INTSTS);

    assign w_launch_req = w_wr && (w_word == A_CMD) && pwdata_i[0] && !w_cmd_busy;
    assign w_launch     = w_launch_req & w_mat_valid;
    assign w_err_set    = w_launch_req & ~w_mat_valid;
    assign w_done_set   = (r_state == ST_RUN) & done_i;

    assign w_clr = (w_wr && (w_word == A_INTSTS)) ? pwdata_i[1:0] : 2'b00;
    assign w_set = {w_err_set, w_done_set};
    // Set takes priority over a same-cycle W1C of the same bit.
    assign w_int_sts_next = (r_int_sts & ~w_clr) | w_set;

    assign pslverr_o = w_access & (~w_mapped |
                       (pwrite_i & ((w_cfg_sel & w_busy) | ((w_word == A_CMD) & w_cmd_busy))));

    always_comb begin
        prdata_o = 32'd0;
        if (w_rd) begin
            case (w_word)
                A_VERSION: prdata_o = VERSION;
                A_SRC:     prdata_o = r_src;
                A_DST:     prdata_o = r_dst;
                A_MATW:    prdata_o = {26'd0, r_mat_w};
                A_STATUS:  prdata_o = {30'd0, w_busy, done_i};
                A_INTEN:   prdata_o = {30'd0, r_int_en};
                A_INTSTS:  prdata_o = {30'd0, r_int_sts};
                default:   prdata_o = 32'd0;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_launch) w_state_next = ST_START;
            ST_START: w_state_next = ST_ACK;
            ST_ACK:   if (!done_i) w_state_next = ST_RUN;
            ST_RUN:   if (done_i) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src     <= 32'd0;
            r_dst     <= 32'd0;
            r_mat_w   <= 6'd0;
            r_int_en  <= 2'd0;
            r_int_sts <= 2'd0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && !w_busy) begin
                if (w_word == A_SRC)  r_src   <= pwdata_i;
                if (w_word == A_DST)  r_dst   <= pwdata_i;
                if (w_word == A_MATW) r_mat_w <= pwdata_i[5:0];
            end
            if (w_wr && (w_word == A_INTEN)) r_int_en <= pwdata_i[1:0];
            r_int_sts <= w_int_sts_next;
            r_irq     <= |(r_int_sts & r_int_en);
        end
    end

    assign src_addr_o  = r_src;
    assign dst_addr_o  = r_dst;
    assign mat_width_o = r_mat_w;
    assign start_o     = (r_state == ST_START);
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_mpdmac_cfg.sv
// Directed bench for mpdmac_cfg: register map, launch handshake, busy errors,
// invalid widths, W1C/set priority and asynchronous reset mid-run.
module tb_mpdmac_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] src_addr, dst_addr;
    logic [5:0]  mat_width;
    logic        start;
    logic        done;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    logic [31:0] rd;
    logic        err;

    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    mpdmac_cfg dut (
        .clk(clk), .rst_n(rst_n),
        .psel_i(psel), .penable_i(penable), .paddr_i(paddr), .pwrite_i(pwrite),
        .pwdata_i(pwdata), .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .src_addr_o(src_addr), .dst_addr_o(dst_addr), .mat_width_o(mat_width),
        .start_o(start), .done_i(done), .irq_o(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns one edge + 1 time unit after the commit edge.
    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic perr);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rdata = prdata; perr = pslverr;
        $display("APB %s addr=%03h wdata=%08h rdata=%08h err=%0b", wr ? "WR" : "RD", a, wd, prdata, pslverr);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_pready", {31'd0, pready}, 32'd0);
        rst_n = 1'b1;

        apb(0, 12'h000, 0, rd, err);
        check("version", rd, 32'h0001_2024);
        for (int a = 12'h100; a <= 12'h118; a += 4) begin
            apb(0, a[11:0], 0, rd, err);
            check("rst_reg", rd, 32'd0);
            check("rst_reg_err", {31'd0, err}, 32'd0);
        end
        apb(0, 12'h200, 0, rd, err);
        check("unmapped_err", {31'd0, err}, 32'd1);
        check("unmapped_data", rd, 32'd0);
        apb(1, 12'h000, 32'h1234, rd, err);
        check("ro_write_err", {31'd0, err}, 32'd0);
        apb(1, 12'h108, 32'hFF, rd, err);
        apb(0, 12'h108, 0, rd, err);
        check("matw_mask", rd, 32'h3F);

        // Normal launch
        done = 1'b1;
        apb(1, 12'h100, 32'h1000, rd, err);
        apb(1, 12'h104, 32'h2000, rd, err);
        apb(1, 12'h108, 32'd4, rd, err);
        apb(1, 12'h114, 32'd1, rd, err);
        apb(1, 12'h10C, 32'd1, rd, err);
        check("cmd_err", {31'd0, err}, 32'd0);
        check("start_pulse", {31'd0, start}, 32'd1);
        check("src_out", src_addr, 32'h1000);
        check("dst_out", dst_addr, 32'h2000);
        check("matw_out", {26'd0, mat_width}, 32'd4);
        @(posedge clk); #1;
        done = 1'b0;
        check("start_one_cycle", {31'd0, start}, 32'd0);
        apb(0, 12'h110, 0, rd, err);
        check("status_busy", rd, 32'd2);
        apb(1, 12'h100, 32'hDEAD, rd, err);
        check("busy_src_err", {31'd0, err}, 32'd1);
        apb(0, 12'h100, 0, rd, err);
        check("busy_src_keep", rd, 32'h1000);
        apb(1, 12'h10C, 32'd1, rd, err);
        check("busy_cmd_err", {31'd0, err}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        done = 1'b1;
        @(posedge clk); #1;
        check("irq_latency", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_done", {31'd0, irq}, 32'd1);
        check("start_count1", start_cnt, 32'd1);
        apb(0, 12'h118, 0, rd, err);
        check("int_sts_done", rd, 32'd1);
        apb(1, 12'h118, 32'd1, rd, err);
        @(posedge clk); #1;
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Invalid widths set err_pend only
        apb(1, 12'h114, 32'd2, rd, err);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] w;
            w = (k == 0) ? 32'd5 : (k == 1) ? 32'd0 : 32'd62;
            apb(1, 12'h108, w, rd, err);
            apb(1, 12'h10C, 32'd1, rd, err);
            check("bad_cmd_err", {31'd0, err}, 32'd0);
            apb(0, 12'h118, 0, rd, err);
            check("bad_int_sts", rd, 32'd2);
            check("bad_irq", {31'd0, irq}, 32'd1);
            check("bad_no_start", start_cnt, 32'd1);
            apb(1, 12'h118, 32'd2, rd, err);
            @(posedge clk); #1;
            check("bad_irq_clr", {31'd0, irq}, 32'd0);
        end

        // W1C colliding with done set
        apb(1, 12'h108, 32'd4, rd, err);
        apb(1, 12'h10C, 32'd1, rd, err);
        @(posedge clk); #1;
        done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h118; pwdata = 32'd1;
        @(posedge clk); #1;
        penable = 1'b1; done = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("APB WR addr=118 wdata=00000001 (collides with done)");
        apb(0, 12'h118, 0, rd, err);
        check("set_wins", rd, 32'd1);
        apb(1, 12'h118, 32'd1, rd, err);
        apb(0, 12'h118, 0, rd, err);
        check("w1c_after", rd, 32'd0);
        check("start_count2", start_cnt, 32'd2);

        // Reset while running
        apb(1, 12'h10C, 32'd1, rd, err);
        @(posedge clk); #1;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_src", src_addr, 32'd0);
        check("arst_matw", {26'd0, mat_width}, 32'd0);
        check("arst_start", {31'd0, start}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; done = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_pulse", start_cnt, 32'd3);
        apb(0, 12'h110, 0, rd, err);
        check("arst_status", rd, 32'd1);
        apb(0, 12'h114, 0, rd, err);
        check("arst_inten", rd, 32'd0);
        apb(1, 12'h108, 32'd2, rd, err);
        apb(1, 12'h10C, 32'd1, rd, err);
        check("relaunch_start", {31'd0, start}, 32'd1);
        check("relaunch_matw", {26'd0, mat_width}, 32'd2);
        @(posedge clk); #1;
        check("start_count3", start_cnt, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
